// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the MIPS32 program loader.
// The source (master) drives the stream; the loader (slave) drives in_ready and the write port.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Loads a big-endian byte stream into MIPS32 instruction memory from address 0,
// appends HLT when missing, and releases the core with a one-cycle start pulse.
module mips32_prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] HLT_WORD  = 32'hfc000000
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 start,
  mips32_prog_loader_if.slave  bus,
  output logic                 cpu_hold,
  output logic                 cpu_start,
  output logic [ADDR_W:0]      word_count,
  output logic                 load_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_APPEND, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state, state_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [23:0]       word_buf, word_buf_n;
  logic [ADDR_W:0]   word_count_n;
  logic              mem_we, mem_we_n;
  logic [ADDR_W-1:0] mem_addr, mem_addr_n;
  logic [31:0]       mem_wdata, mem_wdata_n;
  logic              cpu_hold_n, cpu_start_n, load_err_n;
  logic [31:0]       assembled;
  logic              accept;

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign assembled = {word_buf, bus.in_data};
  assign accept    = bus.in_valid && (state == S_LOAD);

  always_comb begin
    state_n      = state;
    byte_cnt_n   = byte_cnt;
    word_buf_n   = word_buf;
    word_count_n = word_count;
    mem_we_n     = 1'b0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n      = S_LOAD;
          word_count_n = '0;
          byte_cnt_n   = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          word_buf_n = assembled[23:0];
          byte_cnt_n = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            // A full memory turns the next completed word into an overflow error.
            if (word_count == MAX_CNT) begin
              state_n = S_ERR;
            end else begin
              mem_we_n     = 1'b1;
              mem_addr_n   = word_count[ADDR_W-1:0];
              mem_wdata_n  = assembled;
              word_count_n = word_count + CNT_ONE;
              if (bus.in_last)
                state_n = (assembled == HLT_WORD) ? S_DONE : S_APPEND;
            end
          end else if (bus.in_last) begin
            state_n = S_ERR;
          end
        end
      end
      S_APPEND: begin
        if (word_count < MAX_CNT) begin
          mem_we_n     = 1'b1;
          mem_addr_n   = word_count[ADDR_W-1:0];
          mem_wdata_n  = HLT_WORD;
          word_count_n = word_count + CNT_ONE;
          state_n      = S_DONE;
        end else begin
          state_n = S_ERR;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Core outputs follow the state being entered so they change on the same edge.
    cpu_hold_n  = (state_n != S_DONE);
    cpu_start_n = (state_n == S_DONE) && (state != S_DONE);
    load_err_n  = (state_n == S_ERR);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      word_buf   <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      cpu_start  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      byte_cnt   <= byte_cnt_n;
      word_buf   <= word_buf_n;
      word_count <= word_count_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      cpu_hold   <= cpu_hold_n;
      cpu_start  <= cpu_start_n;
      load_err   <= load_err_n;
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: directed and random load sessions
// compared against a program-level model of the expected memory image.
module tb_mips32_prog_loader;

  localparam int          AW  = 4;
  localparam int          MW  = 10;
  localparam logic [31:0] HLT = 32'hfc000000;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cpu_hold, cpu_start, load_err;
  logic [AW:0]   word_count;

  mips32_prog_loader_if #(.ADDR_W(AW)) bus ();

  mips32_prog_loader #(.ADDR_W(AW), .MAX_WORDS(MW), .HLT_WORD(HLT)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .cpu_start  (cpu_start),
    .word_count (word_count),
    .load_err   (load_err)
  );

  always #5 clk1 = ~clk1;

  int          vectors = 0;
  int          miscompares = 0;
  int          start_pulses = 0;
  logic [7:0]  byte_q[$];
  logic [47:0] got_q[$];
  logic [47:0] exp_q[$];

  // Record every memory write and every cycle cpu_start is high, away from the active edge.
  always @(negedge clk1) begin
    if (bus.mem_we) got_q.push_back({16'(bus.mem_addr), bus.mem_wdata});
    if (cpu_start) start_pulses++;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    byte_q.push_back(w[31:24]);
    byte_q.push_back(w[23:16]);
    byte_q.push_back(w[15:8]);
    byte_q.push_back(w[7:0]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HLT) w = w ^ 32'h1;
    return w;
  endfunction

  // Program-level model: whole words land at consecutive addresses up to capacity,
  // a missing trailing HLT is added if room remains, anything else ends in error.
  task automatic build_expected(output int exp_err, output bit exp_done);
    int n, nw, lim;
    logic [31:0] w;
    n   = byte_q.size();
    nw  = n / 4;
    lim = (nw < MW) ? nw : MW;
    exp_q.delete();
    w = '0;
    for (int k = 0; k < lim; k++) begin
      w = {byte_q[4*k], byte_q[4*k+1], byte_q[4*k+2], byte_q[4*k+3]};
      exp_q.push_back({16'(k), w});
    end
    exp_err  = 0;
    exp_done = 1'b0;
    if ((n % 4) != 0 || nw > MW) begin
      exp_err = 1;
    end else if (w == HLT) begin
      exp_done = 1'b1;
    end else if (nw < MW) begin
      exp_q.push_back({16'(nw), HLT});
      exp_done = 1'b1;
    end else begin
      exp_err = 1;
    end
  endtask

  // Offers byte_q one byte at a time, holding each until in_ready is seen at an edge.
  task automatic apply_stimulus(input int gap_max, input int mid_start, input bit use_last);
    for (int i = 0; i < byte_q.size(); i++) begin
      int gaps;
      int tries;
      bit rdy;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (gaps) @(negedge clk1);
      bus.in_valid = 1'b1;
      bus.in_data  = byte_q[i];
      bus.in_last  = use_last && (i == byte_q.size() - 1);
      if (i == mid_start) start = 1'b1;
      tries = 0;
      do begin
        rdy = bus.in_ready;
        @(negedge clk1);
        start = 1'b0;
        tries++;
      end while (!rdy && tries < 30);
      if (!rdy) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL stream_timeout byte=%0d observed=not accepted expected=accepted", i);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_session(input string name, input int gap_max, input int mid_start);
    int e;
    bit d;
    got_q.delete();
    start_pulses = 0;
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
    apply_stimulus(gap_max, mid_start, 1'b1);
    repeat (6) @(negedge clk1);
    build_expected(e, d);
    check_output({name, " write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      check_output($sformatf("%s write[%0d]", name, k),
                   (k < got_q.size()) ? 64'(got_q[k]) : {64{1'bx}}, 64'(exp_q[k]));
    check_output({name, " word_count"}, 64'(word_count), 64'(exp_q.size()));
    check_output({name, " load_err"}, 64'(load_err), 64'(e));
    check_output({name, " cpu_hold"}, 64'(cpu_hold), 64'(!d));
    check_output({name, " cpu_start_cycles"}, 64'(start_pulses), d ? 64'd1 : 64'd0);
    check_output({name, " in_ready"}, 64'(bus.in_ready), 64'd0);
  endtask

  task automatic load_prog9();
    byte_q.delete();
    push_word(32'h2801000a); push_word(32'h28020014); push_word(32'h28030019);
    push_word(32'h0ce77800); push_word(32'h0ce77800); push_word(32'h00222000);
    push_word(32'h0ce77800); push_word(32'h00832800); push_word(32'hfc000000);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset values while rst_n is held low
    #12;
    check_output("rst in_ready",   64'(bus.in_ready),   64'd0);
    check_output("rst mem_we",     64'(bus.mem_we),     64'd0);
    check_output("rst mem_addr",   64'(bus.mem_addr),   64'd0);
    check_output("rst mem_wdata",  64'(bus.mem_wdata),  64'd0);
    check_output("rst cpu_hold",   64'(cpu_hold),       64'd1);
    check_output("rst cpu_start",  64'(cpu_start),      64'd0);
    check_output("rst word_count", 64'(word_count),     64'd0);
    check_output("rst load_err",   64'(load_err),       64'd0);
    @(negedge clk1) rst_n = 1'b1;

    // Nine-word program already ending in HLT
    load_prog9();
    run_session("prog9", 0, -1);

    // Two words, HLT appended at address 2
    byte_q.delete();
    push_word(32'h2801000a); push_word(32'h28020014);
    run_session("append2", 0, -1);

    // Misaligned end after six bytes, then recovery with a random program
    byte_q.delete();
    push_word(rand_word());
    byte_q.push_back(8'($urandom)); byte_q.push_back(8'($urandom));
    run_session("misaligned", 0, -1);
    byte_q.delete();
    for (int k = 0; k < 5; k++) push_word(rand_word());
    run_session("recover", 1, -1);

    // Capacity boundaries
    byte_q.delete();
    for (int k = 0; k < MW; k++) push_word(rand_word());
    run_session("full_no_room", 0, -1);
    byte_q.delete();
    for (int k = 0; k < MW + 1; k++) push_word(rand_word());
    run_session("overflow", 0, -1);
    byte_q.delete();
    for (int k = 0; k < MW - 1; k++) push_word(rand_word());
    push_word(HLT);
    run_session("full_hlt", 0, -1);
    byte_q.delete();
    for (int k = 0; k < MW - 1; k++) push_word(rand_word());
    run_session("fill_last_slot", 0, -1);

    // Gapped stream with an ignored start pulse mid-load
    load_prog9();
    run_session("prog9_gaps", 2, 10);

    // Random programs with random gaps, some ending in HLT
    for (int r = 0; r < 4; r++) begin
      int nw;
      nw = int'($urandom_range(1, MW));
      byte_q.delete();
      for (int k = 0; k < nw - 1; k++) push_word(rand_word());
      push_word(($urandom_range(0, 1) == 1) ? HLT : rand_word());
      run_session($sformatf("random%0d", r), 2, -1);
    end

    // Asynchronous reset mid-load while a write is on the bus
    got_q.delete();
    @(negedge clk1) start = 1'b1;
    @(negedge clk1) start = 1'b0;
    byte_q.delete();
    push_word(32'h2801000a);
    apply_stimulus(0, -1, 1'b0);
    check_output("prereset mem_we",     64'(bus.mem_we),  64'd1);
    check_output("prereset word_count", 64'(word_count),  64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h28;
    #2 rst_n = 1'b0;
    #1;
    check_output("async mem_we",     64'(bus.mem_we),    64'd0);
    check_output("async cpu_hold",   64'(cpu_hold),      64'd1);
    check_output("async in_ready",   64'(bus.in_ready),  64'd0);
    check_output("async word_count", 64'(word_count),    64'd0);
    check_output("async mem_wdata",  64'(bus.mem_wdata), 64'd0);
    bus.in_valid = 1'b0;
    @(negedge clk1) rst_n = 1'b1;
    load_prog9();
    run_session("after_reset", 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
